// File: rtl/hidden_layer_accumulator_pkg.sv
// Shared types and default sizes for the hidden-layer accumulator.
// HIDDEN_BIAS_EN enlarges the weight ROM by one bias row of HIDDEN_NODES words.
package hidden_layer_accumulator_pkg;

   localparam int INPUT_NODES_DEF  = 784;
   localparam int HIDDEN_NODES_DEF = 16;
   localparam int INDEX_W_DEF      = 10;
   localparam int WEIGHT_W_DEF     = 8;
   localparam int ACC_W_DEF        = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FIN,
      DQ_HI,
      DQ_LO,
      MAC,
      BIAS,
      STREAM,
      DONE
   } state_e;

   // The bias row sits directly above the last pixel row when enabled.
   function automatic int romDepth(input int inputNodes, input int hiddenNodes);
`ifdef HIDDEN_BIAS_EN
      return (inputNodes + 1) * hiddenNodes;
`else
      return inputNodes * hiddenNodes;
`endif
   endfunction

   function automatic int romAddrW(input int inputNodes, input int hiddenNodes);
      return $clog2(romDepth(inputNodes, hiddenNodes));
   endfunction

endpackage

// File: rtl/hidden_layer_accumulator_if.sv
// Queue, weight-ROM and result-stream signals of the hidden-layer accumulator.
// master = accumulator side, slave = queue / ROM / activation-stage side.
interface hidden_layer_accumulator_if
   import hidden_layer_accumulator_pkg::*;
#(
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int ADDR_W   = romAddrW(INPUT_NODES_DEF, HIDDEN_NODES_DEF),
   parameter int NODE_W   = $clog2(HIDDEN_NODES_DEF)
);
   logic                       q_finished;
   logic                       q_empty;
   logic [INDEX_W-1:0]         q_index;
   logic                       dequeue;
   logic [ADDR_W-1:0]          w_addr;
   logic signed [WEIGHT_W-1:0] w_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [NODE_W-1:0]          out_node;
   logic signed [ACC_W-1:0]    out_sum;

   modport master (
      input  q_finished, q_empty, q_index, w_data, out_ready,
      output dequeue, w_addr, out_valid, out_node, out_sum
   );

   modport slave (
      output q_finished, q_empty, q_index, w_data, out_ready,
      input  dequeue, w_addr, out_valid, out_node, out_sum
   );

endinterface

// File: rtl/hidden_layer_accumulator_sat_add_signed.sv
// Saturating signed adder: ACC_W accumulator plus sign-extended WEIGHT_W operand, clamped to ACC_W.
module sat_add_signed
   import hidden_layer_accumulator_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF
)(
   input  logic signed [ACC_W-1:0]    acc_i,
   input  logic signed [WEIGHT_W-1:0] w_i,
   output logic signed [ACC_W-1:0]    sum_o
);

   logic signed [ACC_W:0] wide;

   // One guard bit is enough: disagreement between the top two bits means overflow.
   always_comb begin
      wide = $signed({acc_i[ACC_W-1], acc_i})
           + $signed({{(ACC_W + 1 - WEIGHT_W){w_i[WEIGHT_W-1]}}, w_i});
      if (wide[ACC_W] != wide[ACC_W-1])
         sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sum_o = wide[ACC_W-1:0];
   end

endmodule

// File: rtl/hidden_layer_accumulator.sv
// Drains the index queue, adds each active pixel's weight row into per-node accumulators, streams the sums.
// Defining HIDDEN_BIAS_EN inserts a BIAS pass that adds a bias row from the top of the ROM before streaming.
module hidden_layer_accumulator
   import hidden_layer_accumulator_pkg::*;
#(
   parameter int INPUT_NODES  = INPUT_NODES_DEF,
   parameter int HIDDEN_NODES = HIDDEN_NODES_DEF,
   parameter int INDEX_W      = INDEX_W_DEF,
   parameter int WEIGHT_W     = WEIGHT_W_DEF,
   parameter int ACC_W        = ACC_W_DEF,
   parameter int ADDR_W       = romAddrW(INPUT_NODES, HIDDEN_NODES)
)(
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic busy,
   output logic done,
   hidden_layer_accumulator_if.master bus
);

   localparam int NODE_W = (HIDDEN_NODES > 1) ? $clog2(HIDDEN_NODES) : 1;
   localparam int CNT_W  = $clog2(HIDDEN_NODES + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(HIDDEN_NODES);
   localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(HIDDEN_NODES - 1);
   localparam logic [ADDR_W-1:0] ROW_SIZE  = ADDR_W'(HIDDEN_NODES);
   localparam logic [INDEX_W:0]  IDX_LIMIT = (INDEX_W + 1)'(INPUT_NODES);
`ifdef HIDDEN_BIAS_EN
   localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(INPUT_NODES * HIDDEN_NODES);
`endif

   state_e                  state_q;
   logic                    dequeue_q;
   logic                    outValid_q;
   logic                    busy_q;
   logic                    done_q;
   logic [ADDR_W-1:0]       wAddr_q;
   logic [NODE_W-1:0]       outNode_q;
   logic signed [ACC_W-1:0] outSum_q;
   logic [CNT_W-1:0]        macCnt_q;
   logic signed [ACC_W-1:0] accArr_q [HIDDEN_NODES];

   logic [NODE_W-1:0]       accIdx;
   logic signed [ACC_W-1:0] sum_d;
   logic                    macLast;
   logic                    idxBad;
   logic                    drainPt;
   logic                    tailNow;
   logic                    nextIdx;
   logic                    enterStream;
`ifdef HIDDEN_BIAS_EN
   logic                    enterBias;
`endif

   assign bus.dequeue   = dequeue_q;
   assign bus.w_addr    = wAddr_q;
   assign bus.out_valid = outValid_q;
   assign bus.out_node  = outNode_q;
   assign bus.out_sum   = outSum_q;
   assign busy          = busy_q;
   assign done          = done_q;

   // drainPt marks every cycle where the queue decides between another index and the tail of the image.
   always_comb begin
      accIdx  = NODE_W'(macCnt_q - CNT_W'(1));
      macLast = (macCnt_q == LAST_CNT);
      idxBad  = ({1'b0, bus.q_index} >= IDX_LIMIT);
      drainPt = (state_q == WAIT_FIN && bus.q_finished)
             || (state_q == MAC && macLast)
             || (state_q == DQ_LO && idxBad);
      tailNow = drainPt && bus.q_empty;
      nextIdx = drainPt && !bus.q_empty;
`ifdef HIDDEN_BIAS_EN
      enterBias   = tailNow;
      enterStream = (state_q == BIAS) && macLast;
`else
      enterStream = tailNow;
`endif
   end

   sat_add_signed #(
      .ACC_W    (ACC_W),
      .WEIGHT_W (WEIGHT_W)
   ) uSatAdd (
      .acc_i (accArr_q[accIdx]),
      .w_i   (bus.w_data),
      .sum_o (sum_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         dequeue_q  <= 1'b0;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wAddr_q    <= '0;
         outNode_q  <= '0;
         outSum_q   <= '0;
         macCnt_q   <= '0;
         for (int i = 0; i < HIDDEN_NODES; i++) accArr_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  for (int i = 0; i < HIDDEN_NODES; i++) accArr_q[i] <= '0;
                  state_q <= WAIT_FIN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            WAIT_FIN: state_q <= WAIT_FIN;
            DQ_HI: begin
               dequeue_q <= 1'b0;
               state_q   <= DQ_LO;
            end
            DQ_LO: begin
               if (!idxBad) begin
                  wAddr_q  <= ADDR_W'(bus.q_index) * ROW_SIZE;
                  macCnt_q <= '0;
                  state_q  <= MAC;
               end
            end
            // Address runs one cycle ahead of the accumulator it feeds, matching the ROM latency.
`ifdef HIDDEN_BIAS_EN
            MAC, BIAS: begin
`else
            MAC: begin
`endif
               if (macCnt_q != '0) accArr_q[accIdx] <= sum_d;
               if (macCnt_q < LAST_CNT - CNT_W'(1)) wAddr_q <= wAddr_q + ADDR_W'(1);
               if (!macLast) macCnt_q <= macCnt_q + CNT_W'(1);
            end
            STREAM: begin
               if (outValid_q && bus.out_ready) begin
                  if (outNode_q == LAST_NODE) begin
                     outValid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     outNode_q <= outNode_q + NODE_W'(1);
                     outSum_q  <= accArr_q[outNode_q + NODE_W'(1)];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase

         if (nextIdx) begin
            state_q   <= DQ_HI;
            dequeue_q <= 1'b1;
         end
`ifdef HIDDEN_BIAS_EN
         if (enterBias) begin
            state_q  <= BIAS;
            wAddr_q  <= BIAS_BASE;
            macCnt_q <= '0;
         end
`endif
         if (enterStream) begin
            state_q    <= STREAM;
            outValid_q <= 1'b1;
            outNode_q  <= '0;
            outSum_q   <= accArr_q[0];
         end
      end
   end

endmodule

// File: tb/tb_hidden_layer_accumulator.sv
// Self-checking bench for hidden_layer_accumulator: queue and ROM models plus a saturating-sum reference.
module tb_hidden_layer_accumulator;
   import hidden_layer_accumulator_pkg::*;

   localparam int IN_NODES = 784;
   localparam int HN       = 4;
   localparam int AW       = romAddrW(IN_NODES, HN);
   localparam int NW       = 2;
   localparam int MAX_Q    = 400;
   localparam int SAT_MAX  = 32767;
   localparam int SAT_MIN  = -32768;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic start;
   logic busy;
   logic done;

   hidden_layer_accumulator_if #(
      .INDEX_W(10), .WEIGHT_W(8), .ACC_W(16), .ADDR_W(AW), .NODE_W(NW)
   ) bus ();

   hidden_layer_accumulator #(
      .INPUT_NODES(IN_NODES), .HIDDEN_NODES(HN), .INDEX_W(10),
      .WEIGHT_W(8), .ACC_W(16), .ADDR_W(AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int idxMem [MAX_Q];
   int qLen         = 0;
   int head         = 0;
   int dqCount      = 0;
   int dqBackToBack = 0;
   int waChanges    = 0;
   logic qLoad      = 1'b0;
   logic prevDeq    = 1'b0;
   logic [AW-1:0] prevAddr = '0;
   int romMode      = 0;
   int randW [1 << AW];
   int expSum [HN];
   int vectorCount  = 0;
   int missCount    = 0;

   assign bus.q_empty = (head >= qLen);

   // Weight contents per test mode; mode 4 is "all weights 10, bias row = node number".
   function automatic int romFn(input int addr);
      int row;
      int k;
      row = addr / HN;
      k   = addr % HN;
      case (romMode)
         0:       romFn = (row % 50) + 4 * k - 20;
         1:       romFn = 127;
         2:       romFn = -128;
         3:       romFn = randW[addr];
         default: romFn = (row < IN_NODES) ? 10 : k;
      endcase
   endfunction

   function automatic int clampAcc(input int v);
      if (v > SAT_MAX) return SAT_MAX;
      if (v < SAT_MIN) return SAT_MIN;
      return v;
   endfunction

   // Queue head, synchronous ROM and activity monitors.
   always @(posedge clk) begin
      if (qLoad) begin
         head         <= 0;
         dqCount      <= 0;
         dqBackToBack <= 0;
         waChanges    <= 0;
      end else begin
         if (bus.dequeue === 1'b1) begin
            dqCount <= dqCount + 1;
            if (head < qLen) bus.q_index <= 10'(idxMem[head]);
            head <= head + 1;
            if (prevDeq === 1'b1) dqBackToBack <= dqBackToBack + 1;
         end
         if (bus.w_addr !== prevAddr) waChanges <= waChanges + 1;
      end
      prevDeq    <= bus.dequeue;
      prevAddr   <= bus.w_addr;
      bus.w_data <= 8'(romFn(int'(bus.w_addr)));
   end

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectorCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic buildModel();
      for (int k = 0; k < HN; k++) begin
         int acc;
         acc = 0;
         for (int i = 0; i < qLen; i++)
            if (idxMem[i] < IN_NODES) acc = clampAcc(acc + romFn(idxMem[i] * HN + k));
`ifdef HIDDEN_BIAS_EN
         acc = clampAcc(acc + romFn(IN_NODES * HN + k));
`endif
         expSum[k] = acc;
      end
   endtask

   task automatic applyStimulus(input bit pokeBusy);
      bus.q_finished = 1'b0;
      @(negedge clk);
      qLoad = 1'b1;
      @(negedge clk);
      qLoad = 1'b0;
      buildModel();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("busy_wait_fin", busy, 1);
      checkOutput("no_dq_before_fin", dqCount, 0);
      bus.q_finished = 1'b1;
      if (pokeBusy) begin
         repeat (8) @(negedge clk);
         checkOutput("busy_mid", busy, 1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic collectStream(input int stallNode);
      int  nextNode;
      int  cycles;
      bit  stalled;
      nextNode = 0;
      cycles   = 0;
      stalled  = 1'b0;
      bus.out_ready = 1'b1;
      while (nextNode < HN && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         if (bus.out_valid === 1'b1) begin
            if (nextNode == stallNode && !stalled) begin
               stalled = 1'b1;
               bus.out_ready = 1'b0;
               for (int s = 0; s < 5; s++) begin
                  @(negedge clk);
                  checkOutput("stall_valid", bus.out_valid, 1);
                  checkOutput("stall_node", bus.out_node, stallNode);
                  checkOutput("stall_sum", bus.out_sum, expSum[stallNode]);
               end
               bus.out_ready = 1'b1;
            end
            checkOutput("out_node", bus.out_node, nextNode);
            checkOutput("out_sum", bus.out_sum, expSum[nextNode]);
            nextNode++;
         end
      end
      if (nextNode < HN) checkOutput("stream_timeout", nextNode, HN);
   endtask

   task automatic finishImage(input int expDq, input int stallNode);
      collectStream(stallNode);
      @(negedge clk);
      checkOutput("done_high", done, 1);
      checkOutput("busy_low", busy, 0);
      checkOutput("valid_low", bus.out_valid, 0);
      checkOutput("dq_count", dqCount, expDq);
      checkOutput("dq_gap", dqBackToBack, 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dequeue"}, bus.dequeue, 0);
      checkOutput({tag, "_valid"}, bus.out_valid, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_waddr"}, bus.w_addr, 0);
      checkOutput({tag, "_node"}, bus.out_node, 0);
      checkOutput({tag, "_sum"}, bus.out_sum, 0);
   endtask

   initial begin
      int cyc;
      start          = 1'b0;
      bus.q_finished = 1'b0;
      bus.out_ready  = 1'b0;
      for (int a = 0; a < (1 << AW); a++) randW[a] = int'($urandom_range(0, 255)) - 128;

      #2 reset_n = 1'b0;
      #1 checkAllZero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Two active pixels with a row-dependent ramp.
      romMode = 0;
      qLen = 2; idxMem[0] = 3; idxMem[1] = 500;
      applyStimulus(1'b0);
      finishImage(2, -1);

      // Empty image: no dequeues, sums are zero (or the bias row alone).
      qLen = 0;
      applyStimulus(1'b0);
      finishImage(0, -1);
`ifndef HIDDEN_BIAS_EN
      checkOutput("empty_no_waddr", waChanges, 0);
`endif

      // Positive and negative saturation over 300 pixels.
      qLen = 300;
      for (int i = 0; i < 300; i++) idxMem[i] = int'($urandom_range(0, IN_NODES - 1));
      romMode = 1;
      applyStimulus(1'b0);
      finishImage(300, -1);
      checkOutput("sat_pos_model", expSum[0], SAT_MAX);
      romMode = 2;
      applyStimulus(1'b0);
      finishImage(300, -1);

      // Random weights, some out-of-range indices, a stall on node 1 and a start while busy.
      romMode = 3;
      qLen = 24;
      for (int i = 0; i < 24; i++) idxMem[i] = int'($urandom_range(0, 1023));
      idxMem[5]  = 900;
      idxMem[11] = 1023;
      applyStimulus(1'b1);
      finishImage(24, 1);

      // Reset during the MAC of the second index, then a clean rerun of the same queue.
      romMode = 0;
      qLen = 4; idxMem[0] = 10; idxMem[1] = 200; idxMem[2] = 783; idxMem[3] = 42;
      applyStimulus(1'b0);
      cyc = 0;
      while (dqCount < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("reach_second_dq", dqCount, 2);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 checkAllZero("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0);
      finishImage(4, -1);

`ifdef HIDDEN_BIAS_EN
      // Single pixel with weight 10 and bias[k] = k.
      romMode = 4;
      qLen = 1; idxMem[0] = 77;
      applyStimulus(1'b1);
      finishImage(1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
